// File: rtl/fdiv.sv
// Multi-cycle single-precision divider: radix-2 restoring mantissa division
// over 26 iterations, then one normalisation step, guard-bit rounding and packing.
module fdiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        busy,
    output logic        valid,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic               sig_r;
    logic signed [9:0]  e_r;
    logic [24:0]        r_r;
    logic [23:0]        mb_r;
    logic               z1_r;
    logic               z2_r;
    logic [4:0]         cnt_r;
    logic [25:0]        q_r;

    logic               ge_s;
    logic [24:0]        diff_s;
    logic [24:0]        r_next_s;
    logic [22:0]        m_pre_s;
    logic               g_s;
    logic signed [9:0]  ex_pre_s;
    logic [23:0]        m_rnd_s;
    logic signed [9:0]  ex_s;
    logic [31:0]        res_s;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the last divide iteration is at counter value 25
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = DIV;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DIV: begin
                if (cnt_r == 5'd25) begin
                    state_next_s = NORM;
                end else begin
                    state_next_s = DIV;
                end
            end
            NORM:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // One restoring-division step and the normalise/round/pack of the final quotient
    always_comb begin
        ge_s     = (r_r >= {1'b0, mb_r});
        diff_s   = r_r;
        m_pre_s  = 23'd0;
        g_s      = 1'b0;
        ex_pre_s = e_r;
        if (ge_s) begin
            diff_s = r_r - {1'b0, mb_r};
        end else begin
            diff_s = r_r;
        end
        r_next_s = diff_s << 1;

        // Quotient lies in [0.5, 2), so a single right-or-none shift normalises it
        if (q_r[25]) begin
            m_pre_s  = q_r[24:2];
            g_s      = q_r[1];
            ex_pre_s = e_r;
        end else begin
            m_pre_s  = q_r[23:1];
            g_s      = q_r[0];
            ex_pre_s = e_r - 10'sd1;
        end
        m_rnd_s = {1'b0, m_pre_s} + {23'd0, g_s};
        if (m_rnd_s[23]) begin
            ex_s = ex_pre_s + 10'sd1;
        end else begin
            ex_s = ex_pre_s;
        end

        if (z1_r) begin
            res_s = {sig_r, 31'd0};
        end else if (z2_r) begin
            res_s = {sig_r, 8'hFF, 23'd0};
        end else if (ex_s >= 10'sd255) begin
            res_s = {sig_r, 8'hFF, 23'd0};
        end else if (ex_s <= 10'sd0) begin
            res_s = {sig_r, 31'd0};
        end else begin
            res_s = {sig_r, ex_s[7:0], m_rnd_s[22:0]};
        end
    end

    // Operand capture, iteration datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_r  <= 1'b0;
            e_r    <= 10'sd0;
            r_r    <= 25'd0;
            mb_r   <= 24'd0;
            z1_r   <= 1'b0;
            z2_r   <= 1'b0;
            cnt_r  <= 5'd0;
            q_r    <= 26'd0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            result <= 32'd0;
        end else begin
            busy  <= (state_next_s != IDLE);
            valid <= (state_r == NORM);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sig_r <= op1[31] ^ op2[31];
                        e_r   <= $signed({2'b00, op1[30:23]} - {2'b00, op2[30:23]} + 10'd127);
                        r_r   <= {2'b01, op1[22:0]};
                        mb_r  <= {1'b1, op2[22:0]};
                        z1_r  <= (op1[30:23] == 8'd0);
                        z2_r  <= (op2[30:23] == 8'd0);
                        cnt_r <= 5'd0;
                        q_r   <= 26'd0;
                    end
                end
                DIV: begin
                    r_r   <= r_next_s;
                    q_r   <= {q_r[24:0], ge_s};
                    cnt_r <= cnt_r + 5'd1;
                end
                NORM: begin
                    result <= res_s;
                end
                default: begin
                    cnt_r <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv.sv
// Self-checking bench for fdiv: directed vector table, handshake corner cases,
// and random operands checked against an integer-arithmetic reference model.
module tb_fdiv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int checks;
    int errors;

    fdiv dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op1    (op1),
        .op2    (op2),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: quotient of significands as an exact integer division, then
    // normalise, round half-up on the first dropped bit, and apply special cases.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        longint      ea, eb, ex, ma, mb, q, frac, g;
        s  = a[31] ^ b[31];
        ea = longint'(a[30:23]);
        eb = longint'(b[30:23]);
        if (ea == 0) return {s, 31'd0};
        if (eb == 0) return {s, 8'hFF, 23'd0};
        ma = longint'(a[22:0]) + 64'd8388608;
        mb = longint'(b[22:0]) + 64'd8388608;
        q  = (ma * 64'd33554432) / mb;
        ex = ea - eb + 127;
        if (q >= 64'd33554432) begin
            frac = (q / 4) % 64'd8388608;
            g    = (q / 2) % 2;
        end else begin
            ex   = ex - 1;
            frac = (q / 2) % 64'd8388608;
            g    = q % 2;
        end
        frac = frac + g;
        if (frac == 64'd8388608) begin
            frac = 0;
            ex   = ex + 1;
        end
        if (ex >= 255) return {s, 8'hFF, 23'd0};
        if (ex <= 0) return {s, 31'd0};
        return {s, ex[7:0], frac[22:0]};
    endfunction

    // Issue one divide, check busy span, latency, result and single-cycle valid.
    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] req);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1;
        op1   = a;
        op2   = b;
        @(negedge clk);
        start = 1'b0;
        op1   = 32'hDEADBEEF;
        op2   = 32'h12345678;
        cyc      = 1;
        busy_cnt = 0;
        while (!valid && cyc < 60) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 32'(cyc - 1), 32'd27);
        check({name, " busy cycles"}, 32'(busy_cnt), 32'd27);
        check({name, " busy low at valid"}, {31'd0, busy}, 32'd0);
        check({name, " result"}, result, req);
        @(negedge clk);
        check({name, " valid pulse width"}, {31'd0, valid}, 32'd0);
        check({name, " result held"}, result, req);
    endtask

    vec_t vecs[6];

    initial begin
        int pulses;
        logic [31:0] a;
        logic [31:0] b;
        checks = 0;
        errors = 0;
        start  = 1'b0;
        op1    = 32'd0;
        op2    = 32'd0;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset valid", {31'd0, valid}, 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;

        vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000};
        vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB};
        vecs[2] = '{32'h00000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{32'hBF800000, 32'h00000000, 32'hFF800000};
        vecs[4] = '{32'h7F000000, 32'h00800000, 32'h7F800000};
        vecs[5] = '{32'h00800000, 32'h7F000000, 32'h00000000};
        foreach (vecs[i]) begin
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
            check($sformatf("vec%0d model", i), ref_div(vecs[i].a, vecs[i].b), vecs[i].exp);
        end

        // Re-pulsing start while busy must not relaunch or re-latch operands
        @(negedge clk);
        start = 1'b1;
        op1   = 32'h40C00000;
        op2   = 32'h40000000;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        op1   = 32'h41200000;
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            if (valid) begin
                pulses++;
                check("repulse result", result, 32'h40400000);
            end
            @(negedge clk);
        end
        check("repulse valid count", 32'(pulses), 32'd1);

        // Async reset mid-divide aborts with no later valid
        @(negedge clk);
        start = 1'b1;
        op1   = 32'h3F800000;
        op2   = 32'h40400000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort valid", {31'd0, valid}, 32'd0);
        check("abort result", result, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (valid) pulses++;
            @(negedge clk);
        end
        check("abort no valid", 32'(pulses), 32'd0);
        run_div("after abort", 32'h40C00000, 32'h40000000, 32'h40400000);

        // Random operands, mostly with moderate exponents so normal results dominate
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom;
            if (n % 4 != 0) begin
                a[30:23] = 8'($urandom_range(100, 154));
                b[30:23] = 8'($urandom_range(100, 154));
            end
            run_div($sformatf("rand%0d %h/%h", n, a, b), a, b, ref_div(a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
